lsu_pma_unit: RTL
=================

Name: lsu_pma_unit

Overview:
- Parametrised physical-memory-attribute checker for the LSU; generalises the single fixed-IO-window check to NUM_CH independent request channels and a programmable NUM_REGIONS attribute table.
- Per channel: registered response with valid/ready backpressure, reporting IO, access-fault, region index and dTLB-miss status.
- Sits between the LSQ address stage and the LSU router.

Parameters:
- PADDR_W, 56: physical address width; equals PHYSICAL_ADDR_LEN.
- NUM_CH, 2: number of request channels (ch0 = store, ch1 = load by convention).
- NUM_REGIONS, 4: number of table entries; power of two, ≥2.
- DEF_IO_LOW, IO_ADDR_LOW: reset base of region 0.
- DEF_IO_UPP, IO_ADDR_UPP: reset limit of region 0 (exclusive).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush.
- cfg_we_i  in  1  region write strobe.
- cfg_idx_i  in  log2(NUM_REGIONS)  entry index.
- cfg_base_i  in  PADDR_W  region base (inclusive).
- cfg_limit_i  in  PADDR_W  region limit (exclusive).
- cfg_attr_i  in  5  {lock, amo, w, r, io}.
- cfg_vld_i  in  1  entry valid.
- req_vld_i  in  NUM_CH  per-channel request valid.
- req_rdy_o  out  NUM_CH  per-channel request ready.
- req_paddr_i  in  NUM_CH*PADDR_W  physical address.
- req_size_i  in  NUM_CH*2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
- req_is_store_i  in  NUM_CH  store or SC.
- req_is_amo_i  in  NUM_CH  AMO or LR/SC.
- req_dtlb_hit_i  in  NUM_CH  translation valid.
- rsp_vld_o  out  NUM_CH  response valid.
- rsp_rdy_i  in  NUM_CH  consumer ready.
- rsp_is_io_o  out  NUM_CH  access targets an IO region.
- rsp_fault_o  out  NUM_CH  access fault.
- rsp_tlb_miss_o  out  NUM_CH  request carried dtlb_hit=0.
- rsp_region_o  out  NUM_CH*log2(NUM_REGIONS)  matched entry; 0 if none.
- rsp_hit_o  out  NUM_CH  some valid entry matched.

Behaviour:
- Reset (rst=0, async):
  - Region 0 = {DEF_IO_LOW, DEF_IO_UPP, attr io=1, r=1, w=1, amo=0, lock=0}, valid.
  - All other entries invalid, fields 0; all lock bits 0.
  - All rsp_* outputs 0; req_rdy_o = all ones.
- Region match:
  - base <= paddr < limit, unsigned, entry valid.
  - base >= limit is an empty region and never matches.
  - Lowest index wins.
  - No match: default main memory (io=0, r=w=amo=1, hit=0, region=0).
- Fault, evaluated only when dtlb_hit=1, any of:
  - load without r;
  - store without w;
  - amo without amo;
  - paddr not aligned to size (low size bits nonzero).
- dtlb_hit=0: response still issued with tlb_miss=1, io=0, fault=0, hit=0.
- Latency: 1 cycle. A request accepted at edge N presents its response after edge N.
- Handshake, per channel:
  - req_rdy_o = !rsp_vld_q | rsp_rdy_i.
  - Accept when vld & rdy.
  - A held response (vld=1, rdy=0) keeps all fields stable.
  - Back-to-back accepts give one response per cycle.
- Channels are fully independent: no shared state except the table; no cross-channel ordering.
- Config writes:
  - A write takes effect at the next edge.
  - A request sampled in the same cycle as a write uses the old table.
  - Writes to an entry whose lock=1 are ignored.
  - lock clears only on reset.
  - Writing lock=1 commits the whole entry, then locks it.
- Flush:
  - Clears all rsp_vld at the next edge.
  - A request presented in the flush cycle is dropped.
  - The table is unaffected.
- Flush and rsp_rdy in the same cycle: flush wins; no new valid response appears.

Optional Feature:
- Macro: LSU_PMA_CROSS_CHECK_EN.
- Defined:
  - Also compute the last-byte address paddr+(1<<size)-1 (PADDR_W-bit; carry out of the top bit counts as a fault).
  - If the last byte matches a different region index or hit status than the first byte, fault=1.
  - Adds one adder and a second matcher per channel; latency unchanged.
- Undefined: only the first byte is checked. Misaligned accesses already fault, so the difference shows only on aligned accesses that end past a limit.

Decomposition:
- Shared package: PMA attribute bit positions (IO, R, W, AMO, LOCK), size encodings, default IO window constants, and a region-entry struct typedef {vld, base, limit, attr}.
- Sub-module lsu_pma_match:
  - Combinational: address plus table in → hit, idx, attr out.
  - Instantiated once per channel, twice per channel with LSU_PMA_CROSS_CHECK_EN.

Test Plan:
- Reset, then ch1 load at paddr=IO_ADDR_LOW, size=2, dtlb_hit=1 → next cycle rsp_vld=1, is_io=1, fault=0, region=0, hit=1; ch0 idle with rsp_vld=0.
- Program region 1: base 0x8000_0000, limit 0x8000_1000, r=1, w=0. ch0 store at 0x8000_0010, size 3 → fault=1, io=0, region=1. Same address as a load → fault=0.
- Misalignment and TLB miss: load at 0x8000_0002, size 2 → fault=1. Same request with dtlb_hit=0 → tlb_miss=1, fault=0, io=0.
- Lock: write region 2 with lock=1, then rewrite it with base 0 → entry unchanged. A request in the same cycle as a config write sees the old table.
- Backpressure and flush: rsp_rdy=0 for 3 cycles → response held, req_rdy=0. Assert flush → rsp_vld=0 next cycle, flush-cycle request dropped. Async rst mid-stream → all rsp_vld=0 immediately.
- With LSU_PMA_CROSS_CHECK_EN: 8B load at 0x8000_0FFC spanning the region-1 limit → fault=1. Without the macro → fault=1 via misalignment. Aligned 8B load at 0x8000_0FF8 → fault=0 in both builds.

Source files
------------

// File: rtl/lsu_pma_unit_pkg.sv
// PMA checker shared types: attribute bit positions, size codes,
// default IO window, region-entry struct and alignment helpers.
package lsu_pma_unit_pkg;

  localparam int PLEN = 56;

  localparam logic [PLEN-1:0] IO_ADDR_LOW = 56'h0000_1000_0000;
  localparam logic [PLEN-1:0] IO_ADDR_UPP = 56'h0000_2000_0000;

  localparam int ATTR_IO   = 0;
  localparam int ATTR_R    = 1;
  localparam int ATTR_W    = 2;
  localparam int ATTR_AMO  = 3;
  localparam int ATTR_LOCK = 4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef logic [4:0] pma_attr_t;

  localparam pma_attr_t ATTR_IO_DEF = 5'b00111;

  typedef struct packed {
    logic            vld;
    logic [PLEN-1:0] base;
    logic [PLEN-1:0] limit;
    pma_attr_t       attr;
  } pma_entry_t;

  function automatic logic [3:0] size_bytes(logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

  function automatic logic misaligned(
    logic [2:0] lo,
    logic [1:0] sz
  );
    logic [2:0] m;
    m = 3'(size_bytes(sz) - 4'd1);
    return |(lo & m);
  endfunction

endpackage

// File: rtl/lsu_pma_unit_if.sv
// Request/response bundle between the LSQ address stage (master)
// and the PMA unit (slave); all vectors are flat, one slice per channel.
interface lsu_pma_unit_if #(
  parameter int NUM_CH  = 2,
  parameter int PADDR_W = 56,
  parameter int IDX_W   = 2
);

  logic [NUM_CH-1:0]         req_vld_i;
  logic [NUM_CH-1:0]         req_rdy_o;
  logic [NUM_CH*PADDR_W-1:0] req_paddr_i;
  logic [NUM_CH*2-1:0]       req_size_i;
  logic [NUM_CH-1:0]         req_is_store_i;
  logic [NUM_CH-1:0]         req_is_amo_i;
  logic [NUM_CH-1:0]         req_dtlb_hit_i;
  logic [NUM_CH-1:0]         rsp_vld_o;
  logic [NUM_CH-1:0]         rsp_rdy_i;
  logic [NUM_CH-1:0]         rsp_is_io_o;
  logic [NUM_CH-1:0]         rsp_fault_o;
  logic [NUM_CH-1:0]         rsp_tlb_miss_o;
  logic [NUM_CH*IDX_W-1:0]   rsp_region_o;
  logic [NUM_CH-1:0]         rsp_hit_o;

  modport master (
    output req_vld_i, req_paddr_i, req_size_i,
    output req_is_store_i, req_is_amo_i,
    output req_dtlb_hit_i, rsp_rdy_i,
    input  req_rdy_o, rsp_vld_o, rsp_is_io_o,
    input  rsp_fault_o, rsp_tlb_miss_o,
    input  rsp_region_o, rsp_hit_o
  );

  modport slave (
    input  req_vld_i, req_paddr_i, req_size_i,
    input  req_is_store_i, req_is_amo_i,
    input  req_dtlb_hit_i, rsp_rdy_i,
    output req_rdy_o, rsp_vld_o, rsp_is_io_o,
    output rsp_fault_o, rsp_tlb_miss_o,
    output rsp_region_o, rsp_hit_o
  );

endinterface

// File: rtl/lsu_pma_match.sv
// Combinational region lookup: addr_i + table -> hit_o, idx_o, attr_o.
// Lowest matching valid index wins; base >= limit never matches.
module lsu_pma_match
  import lsu_pma_unit_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  localparam int IDX_W = $clog2(NUM_REGIONS)
) (
  input  logic [PLEN-1:0] addr_i,
  input  pma_entry_t      tbl_i [NUM_REGIONS],
  output logic            hit_o,
  output logic [IDX_W-1:0] idx_o,
  output pma_attr_t       attr_o
);

  // Walk downwards so the lowest index is the last to overwrite.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    attr_o = '0;
    for (int i = NUM_REGIONS-1; i >= 0; i--) begin
      if (tbl_i[i].vld &&
          addr_i >= tbl_i[i].base &&
          addr_i <  tbl_i[i].limit) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(i);
        attr_o = tbl_i[i].attr;
      end
    end
  end

endmodule

// File: rtl/lsu_pma_unit.sv
// PMA checker: programmable region table (cfg_*) plus NUM_CH registered
// request/response channels on bus; clk, rst (async low), flush plain.
// Optional LSU_PMA_CROSS_CHECK_EN: also checks the last byte's region.
module lsu_pma_unit
  import lsu_pma_unit_pkg::*;
#(
  parameter int PADDR_W     = PLEN,
  parameter int NUM_CH      = 2,
  parameter int NUM_REGIONS = 4,
  parameter logic [PADDR_W-1:0] DEF_IO_LOW =
    PADDR_W'(IO_ADDR_LOW),
  parameter logic [PADDR_W-1:0] DEF_IO_UPP =
    PADDR_W'(IO_ADDR_UPP),
  localparam int IDX_W = $clog2(NUM_REGIONS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [PADDR_W-1:0] cfg_base_i,
  input  logic [PADDR_W-1:0] cfg_limit_i,
  input  pma_attr_t          cfg_attr_i,
  input  logic               cfg_vld_i,
  lsu_pma_unit_if.slave      bus
);

  pma_entry_t tbl_q [NUM_REGIONS];
  logic       wr_ok;

  // Locked entries ignore writes; a lock write commits then locks.
  assign wr_ok = cfg_we_i & ~tbl_q[cfg_idx_i].attr[ATTR_LOCK];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGIONS; i++)
        tbl_q[i] <= '0;
      tbl_q[0] <= '{vld:   1'b1,
                    base:  PLEN'(DEF_IO_LOW),
                    limit: PLEN'(DEF_IO_UPP),
                    attr:  ATTR_IO_DEF};
    end else if (wr_ok) begin
      tbl_q[cfg_idx_i] <= '{vld:   cfg_vld_i,
                            base:  PLEN'(cfg_base_i),
                            limit: PLEN'(cfg_limit_i),
                            attr:  cfg_attr_i};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PADDR_W-1:0] paddr;
    logic [1:0]         size;
    logic               st, amo, tlb;
    logic               m_hit;
    logic [IDX_W-1:0]   m_idx;
    pma_attr_t          m_attr;
    logic               unused_lock;
    logic               span_bad;
    logic               a_io, a_r, a_w, a_amo;
    logic               io_d, fault_d, hit_d;
    logic [IDX_W-1:0]   reg_d;
    logic               rdy, acc;
    logic               vld_q, io_q, fault_q;
    logic               miss_q, hit_q;
    logic [IDX_W-1:0]   reg_q;

    assign paddr = bus.req_paddr_i[c*PADDR_W +: PADDR_W];
    assign size  = bus.req_size_i[c*2 +: 2];
    assign st    = bus.req_is_store_i[c];
    assign amo   = bus.req_is_amo_i[c];
    assign tlb   = bus.req_dtlb_hit_i[c];

    lsu_pma_match #(.NUM_REGIONS(NUM_REGIONS)) u_first (
      .addr_i (PLEN'(paddr)),
      .tbl_i  (tbl_q),
      .hit_o  (m_hit),
      .idx_o  (m_idx),
      .attr_o (m_attr)
    );

    assign unused_lock = m_attr[ATTR_LOCK];

`ifdef LSU_PMA_CROSS_CHECK_EN
    localparam int LW = PADDR_W + 1;
    logic [LW-1:0]    last;
    logic             l_hit;
    logic [IDX_W-1:0] l_idx;
    pma_attr_t        l_attr;
    logic             unused_l_attr;

    // Extra bit catches wrap past the top of the address space.
    assign last = {1'b0, paddr}
                + LW'(size_bytes(size)) - LW'(1);

    lsu_pma_match #(.NUM_REGIONS(NUM_REGIONS)) u_last (
      .addr_i (PLEN'(last[PADDR_W-1:0])),
      .tbl_i  (tbl_q),
      .hit_o  (l_hit),
      .idx_o  (l_idx),
      .attr_o (l_attr)
    );

    assign unused_l_attr = ^l_attr;
    assign span_bad = last[PADDR_W]
                    | (l_hit != m_hit)
                    | (l_idx != m_idx);
`else
    assign span_bad = 1'b0;
`endif

    // No match falls back to cacheable main memory.
    always_comb begin
      a_io  = 1'b0;
      a_r   = 1'b1;
      a_w   = 1'b1;
      a_amo = 1'b1;
      if (m_hit) begin
        a_io  = m_attr[ATTR_IO];
        a_r   = m_attr[ATTR_R];
        a_w   = m_attr[ATTR_W];
        a_amo = m_attr[ATTR_AMO];
      end
      hit_d   = tlb & m_hit;
      reg_d   = hit_d ? m_idx : '0;
      io_d    = tlb & a_io;
      fault_d = tlb & ((amo & ~a_amo)
                     | (st & ~a_w)
                     | (~st & ~amo & ~a_r)
                     | misaligned(paddr[2:0], size)
                     | span_bad);
    end

    assign rdy = ~vld_q | bus.rsp_rdy_i[c];
    assign acc = bus.req_vld_i[c] & rdy & ~flush;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q   <= 1'b0;
        io_q    <= 1'b0;
        fault_q <= 1'b0;
        miss_q  <= 1'b0;
        hit_q   <= 1'b0;
        reg_q   <= '0;
      end else begin
        if (flush)
          vld_q <= 1'b0;
        else if (acc)
          vld_q <= 1'b1;
        else if (bus.rsp_rdy_i[c])
          vld_q <= 1'b0;
        if (acc) begin
          io_q    <= io_d;
          fault_q <= fault_d;
          miss_q  <= ~tlb;
          hit_q   <= hit_d;
          reg_q   <= reg_d;
        end
      end
    end

    assign bus.req_rdy_o[c]      = rdy;
    assign bus.rsp_vld_o[c]      = vld_q;
    assign bus.rsp_is_io_o[c]    = io_q;
    assign bus.rsp_fault_o[c]    = fault_q;
    assign bus.rsp_tlb_miss_o[c] = miss_q;
    assign bus.rsp_hit_o[c]      = hit_q;
    assign bus.rsp_region_o[c*IDX_W +: IDX_W] = reg_q;
  end

endmodule
